// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder controller.
// master drives the request side, slave (the controller) returns the result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder cell is reused LSB-first
// over WIDTH cycles, with the carry held in a flip-flop between bit positions.
module serial_adder_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 4,
   parameter int CW    = 5
) (
   input logic                clk,
   input logic                rst,
   serial_adder_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] areg_r;
   logic [WIDTH-1:0] breg_r;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;
   logic             cout_r;
   logic             ovf_r;
   logic             fa_s_s;
   logic             fa_co_s;

   serial_adder_fa_cell u_fa (
      .a  (areg_r[0]),
      .b  (breg_r[0]),
      .ci (carry_r),
      .s  (fa_s_s),
      .co (fa_co_s)
   );

   // Sequencer: operand load, per-bit shift through the cell, result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         areg_r  <= '0;
         breg_r  <= '0;
         sum_r   <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  // Subtraction is a + ~b + 1: invert b and seed the carry.
                  areg_r  <= bus.a;
                  breg_r  <= bus.sub ? ~bus.b : bus.b;
                  carry_r <= bus.sub;
                  cnt_r   <= '0;
                  sum_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sum_r   <= {fa_s_s, sum_r[WIDTH-1:1]};
               carry_r <= fa_co_s;
               areg_r  <= {1'b0, areg_r[WIDTH-1:1]};
               breg_r  <= {1'b0, breg_r[WIDTH-1:1]};
               cnt_r   <= cnt_r + CW'(1);
               if (cnt_r == CW'(WIDTH - 1)) begin
                  // carry_r here is the carry into the MSB position.
                  ovf_r   <= carry_r ^ fa_co_s;
                  cout_r  <= fa_co_s;
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases, an exhaustive
// sweep and random operations compared against an arithmetic reference model.
module tb_serial_adder_ctrl;
   localparam int W  = 4;
   localparam int CW = 5;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
   endtask

   // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
   function automatic logic [W+1:0] ref_model(input int ua, input int ub, input bit s);
      int   bv, total, sa, sb, exact;
      logic c, o;
      logic [W-1:0] sm;
      bv    = s ? ((~ub) & ((1 << W) - 1)) : ub;
      total = ua + bv + (s ? 1 : 0);
      sm    = W'(total % (1 << W));
      c     = (total >= (1 << W));
      sa    = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb    = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      exact = s ? sa - sb : sa + sb;
      o     = (exact > (1 << (W - 1)) - 1) || (exact < -(1 << (W - 1)));
      return {o, c, sm};
   endfunction

   // Waits (bounded) for done, scrambling operands meanwhile; counts busy cycles.
   task automatic wait_done(output int cyc, output int busy_n, output bit seen);
      cyc = 0; busy_n = 0; seen = 1'b0;
      while (cyc < 20) begin
         if (bus.done) begin
            seen = 1'b1;
            if (bus.busy) busy_n++;
            break;
         end
         if (bus.busy) busy_n++;
         bus.a   = W'($urandom);
         bus.b   = W'($urandom);
         bus.sub = 1'($urandom);
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag, input int ua, input int ub, input bit s);
      logic [W+1:0] e;
      e = ref_model(ua, ub, s);
      check_val({tag, "_sum"},  32'(bus.sum),  32'(e[W-1:0]));
      check_val({tag, "_cout"}, 32'(bus.cout), 32'(e[W]));
      check_val({tag, "_ovf"},  32'(bus.ovf),  32'(e[W+1]));
   endtask

   task automatic run_op(input string tag, input int ua, input int ub, input bit s);
      int cyc, busy_n;
      bit seen;
      @(negedge clk);
      bus.a = W'(ua); bus.b = W'(ub); bus.sub = s; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, busy_n, seen);
      check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_val({tag, "_latency"}, 32'(cyc), 32'(W));
      check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(W + 1));
      check_result(tag, ua, ub, s);
      @(negedge clk);
      check_val({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check_val({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, "_done"}, 32'(bus.done), 32'd0);
      check_val({tag, "_sum"},  32'(bus.sum),  32'd0);
      check_val({tag, "_cout"}, 32'(bus.cout), 32'd0);
      check_val({tag, "_ovf"},  32'(bus.ovf),  32'd0);
   endtask

   initial begin
      int  cyc, busy_n;
      bit  seen;
      n_checks = 0; n_pass = 0;
      rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      run_op("add_3_5", 3, 5, 1'b0);
      run_op("add_15_1", 15, 1, 1'b0);
      run_op("add_0_0", 0, 0, 1'b0);
      run_op("sub_5_3", 5, 3, 1'b1);
      run_op("sub_3_5", 3, 5, 1'b1);
      run_op("sub_8_1", 8, 1, 1'b1);

      // Start held high: back-to-back with one idle cycle, start ignored in DONE.
      @(negedge clk);
      bus.a = 4'd3; bus.b = 4'd5; bus.sub = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      wait_done(cyc, busy_n, seen);
      check_val("b2b_first_seen", 32'(seen), 32'd1);
      check_result("b2b_first", 3, 5, 1'b0);
      bus.a = 4'd2; bus.b = 4'd9; bus.sub = 1'b0;
      @(negedge clk);
      check_val("b2b_gap_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check_val("b2b_rerun_busy", 32'(bus.busy), 32'd1);
      wait_done(cyc, busy_n, seen);
      check_val("b2b_second_seen", 32'(seen), 32'd1);
      check_result("b2b_second", 2, 9, 1'b0);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("b2b_stop_idle", 32'(bus.busy), 32'd0);

      // Reset mid-RUN, then reset and start together.
      run_op("pre_rst", 3, 5, 1'b0);
      @(negedge clk);
      bus.a = 4'd15; bus.b = 4'd1; bus.sub = 1'b0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("rst_mid_run");
      bus.start = 1'b1;
      @(negedge clk);
      check_val("rst_start_same", 32'(bus.busy), 32'd0);
      rst = 1'b0; bus.start = 1'b0;
      run_op("post_rst_6_7", 6, 7, 1'b0);

      for (int s = 0; s < 2; s++)
         for (int ia = 0; ia < (1 << W); ia++)
            for (int ib = 0; ib < (1 << W); ib++)
               run_op("sweep", ia, ib, s[0]);

      for (int k = 0; k < 40; k++)
         run_op("random", int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)),
                1'($urandom));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder/subtractor controller. It time-shares one 1-bit full adder cell, instantiated internally, across WIDTH bit positions. Operands are loaded on a start pulse and shifted LSB-first through the cell, with the carry held in a flip-flop between bits. It returns the WIDTH-bit result with done/busy handshake flags. It is the sequencing layer above the full adder cell in the lab datapath.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32).
CW, 5, counter width; must satisfy 2^CW > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request an operation; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress (RUN and DONE)
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; holds until the next accepted start
cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  output  1  two's-complement overflow flag

Behaviour:
- Reset (rst=1 at a clk edge): state returns to IDLE from any state, including mid-RUN. busy, done, sum, cout, ovf, the internal shift registers, the carry FF and the counter all clear to 0.
- IDLE:
  - busy=0, done=0.
  - On start=1: areg<=a; breg<=sub ? ~b : b; carry<=sub; cnt<=0; sum<=0; next state RUN.
- RUN (exactly WIDTH cycles):
  - Each cycle the full adder sees (areg[0], breg[0], carry).
  - sum shifts right, with the cell's s entering sum[WIDTH-1].
  - carry<=cell cout; areg and breg shift right; cnt<=cnt+1.
  - On the cycle with cnt==WIDTH-1: latch ovf <= carry XOR cell cout (carry-in to MSB XOR carry-out of MSB); latch cout <= cell cout; next state DONE.
- DONE (one cycle): done=1, busy=1; next state IDLE unconditionally.
- Latency:
  - busy rises on the edge that accepts start (edge E0).
  - done is high during the cycle following edge E(WIDTH), i.e. WIDTH+1 cycles after start is presented.
  - Next start is accepted at the earliest at edge E(WIDTH+2).
- start while busy=1, including the DONE cycle: ignored, no queuing. a, b and sub may change freely after acceptance without affecting the result.
- sum, cout and ovf are stable from the DONE cycle until the next accepted start, where sum clears to 0. During RUN, sum is partial and undefined for consumers.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - For sub, the result equals a + ~b + 1.
  - cout is the raw carry-out, with no inversion for borrow.
- rst and start asserted in the same cycle: reset wins and the operation is not accepted.

Test Plan:
- WIDTH=4, add a=3, b=5: done after 5 cycles, sum=8, cout=0, ovf=1; busy high for exactly 5 cycles.
- Add a=15, b=1: sum=0, cout=1, ovf=0. Add a=0, b=0: sum=0, cout=0, ovf=0.
- Sub a=5, b=3: sum=2, cout=1, ovf=0. Sub a=3, b=5: sum=14, cout=0, ovf=0. Sub a=8, b=1: sum=7, ovf=1.
- Start held high continuously: operations complete back-to-back with exactly one IDLE cycle between done and the next busy. Operands changed mid-RUN do not alter the result.
- rst pulsed at RUN cycle 2: next cycle all outputs are 0 and state is IDLE; a fresh start (a=6, b=7, add) then yields sum=13, cout=0, ovf=1.
- Exhaustive sweep of all a, b, sub (512 cases): sum, cout and ovf match the reference model, and done pulses exactly once per operation.
